// File: rtl/axis_rr_arb_mux_if.sv
// ---------------------------------------------------------------------------
// axis_rr_arb_mux_if
//   Bundle of the N-source / 1-sink AXI-stream signals used by
//   axis_rr_arb_mux.
//
//   Source side (N ports, port i at bits [i*WIDTH +: WIDTH]):
//     s_tdata  [N*WIDTH]  source data
//     s_tvalid [N]        per-source valid
//     s_tlast  [N]        per-source end of packet
//     s_tready [N]        per-source ready (driven by the mux)
//   Sink side:
//     m_tdata  [WIDTH]    output data
//     m_tlast             output end of packet
//     m_tid    [IDW]      index of the source that produced the beat
//     m_tvalid            output valid
//     m_tready            output ready (driven by the sink)
//
//   Modports:
//     master : the mux itself (owns s_tready and every m_* except m_tready)
//     slave  : the surrounding sources and sink
// ---------------------------------------------------------------------------
interface axis_rr_arb_mux_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
);
    logic [N*WIDTH-1:0] s_tdata;
    logic [N-1:0]       s_tvalid;
    logic [N-1:0]       s_tlast;
    logic [N-1:0]       s_tready;
    logic [WIDTH-1:0]   m_tdata;
    logic               m_tlast;
    logic [IDW-1:0]     m_tid;
    logic               m_tvalid;
    logic               m_tready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tlast, m_tid, m_tvalid
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tlast, m_tid, m_tvalid
    );
endinterface

// File: rtl/axis_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// axis_rr_arb_mux
//   Packet-aware round-robin arbiter sharing one AXI-stream sink between N
//   AXI-stream sources. A grant is held until the granted source's tlast beat
//   is accepted (LOCK_PKT = 1) or for a single beat (LOCK_PKT = 0). Accepted
//   beats go through a 2-slot buffer so sink backpressure never reaches the
//   sources combinationally; output latency is one cycle.
//
//   Ports:
//     clk        clock
//     rst        synchronous, active-high reset
//     axis       axis_rr_arb_mux_if.master (s_* sources, m_* sink)
//   Optional (macro AXIS_ARB_STATS_EN defined):
//     stat_pkts  [N*16] per-port saturating packet counters, port i at [i*16 +: 16]
//     stat_clr   synchronous clear of all counters (wins over an increment)
//
//   Parameters: N (2..16), WIDTH, IDW (2^IDW >= N), LOCK_PKT (0/1).
// ---------------------------------------------------------------------------
module axis_rr_arb_mux #(
    parameter int N        = 4,
    parameter int WIDTH    = 32,
    parameter int IDW      = 2,
    parameter int LOCK_PKT = 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef AXIS_ARB_STATS_EN
    output logic [N*16-1:0] stat_pkts,
    input  logic            stat_clr,
`endif
    axis_rr_arb_mux_if.master axis
);

    localparam int SW = $clog2(N);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_grant;
    logic [IDW-1:0]   w_grant_nxt;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   w_last_nxt;

    logic [IDW-1:0]   w_pick;
    logic             w_any_req;
    logic [SW-1:0]    w_gidx;

    logic [1:0]       r_wptr;
    logic [1:0]       r_rptr;
    logic [1:0]       w_count;

    logic [WIDTH-1:0] r_buf_data [2];
    logic             r_buf_last [2];
    logic [IDW-1:0]   r_buf_id   [2];

    logic             w_slot_free;
    logic             w_accept;
    logic             w_pop;
    logic             w_release;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;

    assign w_gidx = SW'(r_grant);

    // Round-robin search: first requester after r_last, wrapping modulo N.
    always_comb begin : pick_proc
        int unsigned idx;
        w_pick    = '0;
        w_any_req = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(r_last) + k) % N;
            if (!w_any_req && axis.s_tvalid[SW'(idx)]) begin
                w_any_req = 1'b1;
                w_pick    = IDW'(idx);
            end
        end
    end

    // Wrapping pointers: the 2-bit difference distinguishes full from empty.
    assign w_count     = r_wptr - r_rptr;
    assign w_slot_free = (r_state == ST_GRANT) && (w_count < 2'd2);
    assign w_sel_data  = axis.s_tdata[w_gidx*WIDTH +: WIDTH];
    assign w_sel_last  = axis.s_tlast[w_gidx];
    assign w_accept    = w_slot_free && axis.s_tvalid[w_gidx];
    assign w_pop       = axis.m_tvalid && axis.m_tready;
    assign w_release   = w_accept && (w_sel_last || (LOCK_PKT == 0));

    always_comb begin
        axis.s_tready = '0;
        if (w_slot_free) begin
            axis.s_tready = N'(1) << w_gidx;
        end
    end

    assign axis.m_tvalid = (w_count != 2'd0);
    assign axis.m_tdata  = r_buf_data[r_rptr[0]];
    assign axis.m_tlast  = r_buf_last[r_rptr[0]];
    assign axis.m_tid    = r_buf_id[r_rptr[0]];

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = w_pick;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_grant;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= IDW'(N - 1);
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            if (w_accept) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
        end
    end

    // Payload storage needs no reset: m_tvalid masks stale slots.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_data[r_wptr[0]] <= w_sel_data;
            r_buf_last[r_wptr[0]] <= w_sel_last;
            r_buf_id[r_wptr[0]]   <= r_grant;
        end
    end

`ifdef AXIS_ARB_STATS_EN
    logic [15:0] r_stat [N];

    // A packet is counted exactly when its grant is released.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (rst || stat_clr) begin
                r_stat[i] <= '0;
            end else if (w_release && (w_gidx == SW'(i)) && (r_stat[i] != 16'hFFFF)) begin
                r_stat[i] <= r_stat[i] + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_stat_out
        assign stat_pkts[gi*16 +: 16] = r_stat[gi];
    end
`endif

endmodule

// File: tb/tb_axis_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arb_mux
//   Bench for axis_rr_arb_mux (N=4, WIDTH=32, IDW=2, LOCK_PKT=1).
//   Sources are fed from per-port beat queues; a transaction-level model
//   tracks the round-robin grant, the expected buffered beats and the
//   sink-side ordering. Stats checks are built when AXIS_ARB_STATS_EN is set.
// ---------------------------------------------------------------------------
module tb_axis_rr_arb_mux;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int unsigned gap;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int unsigned tid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_rr_arb_mux_if #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) bus ();

`ifdef AXIS_ARB_STATS_EN
    logic [N*16-1:0] stat_pkts;
    logic            stat_clr = 1'b0;
`endif

    axis_rr_arb_mux #(
        .N(N), .WIDTH(WIDTH), .IDW(IDW), .LOCK_PKT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef AXIS_ARB_STATS_EN
        .stat_pkts(stat_pkts),
        .stat_clr(stat_clr),
`endif
        .axis(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // stimulus state
    beat_t       src_q [N][$];
    int unsigned gap_cnt [N];
    logic [N-1:0] acc = '0;
    int unsigned seq = 0;
    logic want_rst = 1'b1;
    logic want_rdy = 1'b1;
    logic rnd_rdy  = 1'b0;
    logic want_clr = 1'b0;

    // reference model state
    bit          arbitrating = 1'b1;
    int unsigned mlast = N - 1;
    int unsigned mg = 0;
    exp_t        exp_q [$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [1:0]  prev_tid;
    bit          pkt_open = 1'b0;
    int unsigned open_tid = 0;
    int unsigned out_tid [$];
    logic [31:0] out_data [$];
    int          out_cyc [$];
    int          cyc = 0;

    function automatic int unsigned rr_pick(input logic [N-1:0] v, input int unsigned from);
        for (int unsigned k = 1; k <= N; k++) begin
            if (v[(from + k) % N]) return (from + k) % N;
        end
        return 0;
    endfunction

    task automatic push_beat(input int unsigned p, input logic last, input int unsigned gap);
        beat_t b;
        b.data = {8'(p), 24'(seq)};
        b.last = last;
        b.gap  = gap;
        seq++;
        if (src_q[p].size() == 0) gap_cnt[p] = gap;
        src_q[p].push_back(b);
    endtask

    task automatic monitor();
        int unsigned  n_before;
        exp_t         e;
        logic [N-1:0] exp_rdy;
        cyc++;
        if (rst) begin
            exp_q.delete();
            arbitrating = 1'b1;
            mlast       = N - 1;
            acc         = '0;
            prev_stall  = 1'b0;
            pkt_open    = 1'b0;
            return;
        end
        // sink side first: what is visible now was accepted in earlier cycles
        check("m_tvalid", 64'(bus.m_tvalid), 64'(exp_q.size() != 0));
        if (prev_stall) begin
            check("hold_data", 64'(bus.m_tdata), 64'(prev_data));
            check("hold_last", 64'(bus.m_tlast), 64'(prev_last));
            check("hold_tid", 64'(bus.m_tid), 64'(prev_tid));
        end
        n_before = exp_q.size();
        if (bus.m_tvalid && bus.m_tready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", 64'(bus.m_tdata), 64'(e.data));
            check("out_last", 64'(bus.m_tlast), 64'(e.last));
            check("out_tid", 64'(bus.m_tid), 64'(e.tid));
            if (pkt_open) check("no_interleave", 64'(bus.m_tid), 64'(open_tid));
            pkt_open = !bus.m_tlast;
            open_tid = bus.m_tid;
            out_tid.push_back(bus.m_tid);
            out_data.push_back(bus.m_tdata);
            out_cyc.push_back(cyc);
        end
        // source side
        acc = bus.s_tvalid & bus.s_tready;
        if (arbitrating) begin
            check("idle_ready", 64'(bus.s_tready), 64'(0));
            if (bus.s_tvalid != '0) begin
                mg          = rr_pick(bus.s_tvalid, mlast);
                arbitrating = 1'b0;
            end
        end else begin
            exp_rdy = (n_before < 2) ? (N'(1) << mg) : '0;
            check("grant_ready", 64'(bus.s_tready), 64'(exp_rdy));
            if (bus.s_tvalid[mg] && bus.s_tready[mg]) begin
                e.data = bus.s_tdata[mg*WIDTH +: WIDTH];
                e.last = bus.s_tlast[mg];
                e.tid  = mg;
                exp_q.push_back(e);
                if (e.last) begin
                    mlast       = mg;
                    arbitrating = 1'b1;
                end
            end
        end
        prev_stall = bus.m_tvalid && !bus.m_tready;
        prev_data  = bus.m_tdata;
        prev_last  = bus.m_tlast;
        prev_tid   = bus.m_tid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        rst          = want_rst;
        bus.m_tready = rnd_rdy ? ($urandom_range(0, 3) != 0) : want_rdy;
`ifdef AXIS_ARB_STATS_EN
        stat_clr     = want_clr;
`endif
        for (int unsigned p = 0; p < N; p++) begin
            if (acc[p] && src_q[p].size() != 0) begin
                void'(src_q[p].pop_front());
                if (src_q[p].size() != 0) gap_cnt[p] = src_q[p][0].gap;
            end
            if (src_q[p].size() != 0 && gap_cnt[p] == 0) begin
                bus.s_tvalid[p]                = 1'b1;
                bus.s_tdata[p*WIDTH +: WIDTH] = src_q[p][0].data;
                bus.s_tlast[p]                 = src_q[p][0].last;
            end else begin
                if (src_q[p].size() != 0) gap_cnt[p]--;
                bus.s_tvalid[p]                = 1'b0;
                bus.s_tdata[p*WIDTH +: WIDTH] = $urandom;
                bus.s_tlast[p]                 = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset(input int n);
        for (int unsigned p = 0; p < N; p++) src_q[p].delete();
        acc      = '0;
        want_rst = 1'b1;
        repeat (n) step();
        want_rst = 1'b0;
    endtask

    task automatic clear_log();
        out_tid.delete();
        out_data.delete();
        out_cyc.delete();
    endtask

    task automatic drain(input string tag, input int budget);
        bit done;
        int n;
        done = 1'b0;
        n    = 0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (acc == '0) && (exp_q.size() == 0);
            for (int unsigned p = 0; p < N; p++) if (src_q[p].size() != 0) done = 1'b0;
        end
        check(tag, 64'(done), 64'(1));
    endtask

    task automatic check_tids(input string tag, input int unsigned exp_ids [$]);
        check({tag, "_count"}, 64'(out_tid.size()), 64'(exp_ids.size()));
        for (int i = 0; i < exp_ids.size() && i < out_tid.size(); i++) begin
            check(tag, 64'(out_tid[i]), 64'(exp_ids[i]));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int unsigned exp_ids [$];
        logic [31:0] t4_exp [$];
        logic [31:0] stall_data;
        int          n;
        int          pushed;
        int unsigned len;

        bus.s_tdata  = '0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        for (int unsigned p = 0; p < N; p++) gap_cnt[p] = 0;

        // reset state
        do_reset(3);
        check("rst_s_tready", 64'(bus.s_tready), 64'(0));
        check("rst_m_tvalid", 64'(bus.m_tvalid), 64'(0));

        // T1: ports 0 and 2 each hold a 3-beat packet at reset release
        want_rst = 1'b1;
        for (int b = 0; b < 3; b++) push_beat(0, b == 2, 0);
        for (int b = 0; b < 3; b++) push_beat(2, b == 2, 0);
        want_rst = 1'b0;
        clear_log();
        drain("t1_drain", 60);
        exp_ids = '{0, 0, 0, 2, 2, 2};
        check_tids("t1_tid", exp_ids);
        if (out_cyc.size() >= 4) check("t1_bubble", 64'(out_cyc[3] - out_cyc[2]), 64'(2));

        // T2: all four ports valid with 1-beat packets; pointer continues from 2
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int unsigned p = 0; p < N; p++) push_beat(p, 1'b1, 0);
        drain("t2_drain", 60);
        exp_ids.delete();
        for (int unsigned i = 0; i < 2 * N; i++) exp_ids.push_back((2 + 1 + i) % N);
        check_tids("t2_tid", exp_ids);
        for (int i = 1; i < out_cyc.size(); i++) check("t2_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'(2));

        // T3: granted port 1 stalls mid-packet; port 3 waits throughout
        do_reset(3);
        clear_log();
        push_beat(1, 1'b0, 0);
        push_beat(1, 1'b0, 0);
        push_beat(1, 1'b1, 5);
        push_beat(3, 1'b1, 0);
        drain("t3_drain", 60);
        exp_ids = '{1, 1, 1, 3};
        check_tids("t3_tid", exp_ids);

        // T4: sink stalls for 10 cycles during a 6-beat packet
        do_reset(3);
        clear_log();
        want_rdy = 1'b1;
        for (int b = 0; b < 6; b++) push_beat(0, b == 5, 0);
        t4_exp.delete();
        for (int i = 0; i < 6; i++) t4_exp.push_back(src_q[0][i].data);
        n = 0;
        while (out_tid.size() == 0 && n < 20) begin
            step();
            n++;
        end
        check("t4_first_out", 64'(out_tid.size()), 64'(1));
        want_rdy = 1'b0;
        step();
        stall_data = bus.m_tdata;
        repeat (9) step();
        check("t4_full_ready", 64'(bus.s_tready), 64'(0));
        check("t4_stall_valid", 64'(bus.m_tvalid), 64'(1));
        check("t4_stall_data", 64'(bus.m_tdata), 64'(stall_data));
        want_rdy = 1'b1;
        drain("t4_drain", 60);
        check("t4_count", 64'(out_data.size()), 64'(6));
        for (int i = 0; i < 6 && i < out_data.size(); i++) check("t4_order", 64'(out_data[i]), 64'(t4_exp[i]));

        // T5: reset in the middle of a packet restores port-0 priority
        do_reset(3);
        push_beat(1, 1'b1, 0);
        drain("t5_pre_drain", 30);
        for (int b = 0; b < 4; b++) push_beat(3, b == 3, 0);
        n = 0;
        while (src_q[3].size() > 2 && n < 20) begin
            step();
            n++;
        end
        check("t5_mid_pkt", 64'(src_q[3].size()), 64'(2));
        for (int unsigned p = 0; p < N; p++) src_q[p].delete();
        acc      = '0;
        want_rst = 1'b1;
        step();
        step();
        check("t5_rst_m_tvalid", 64'(bus.m_tvalid), 64'(0));
        check("t5_rst_s_tready", 64'(bus.s_tready), 64'(0));
        want_rst = 1'b0;
        clear_log();
        push_beat(0, 1'b1, 0);
        push_beat(3, 1'b1, 0);
        drain("t5_drain", 30);
        exp_ids = '{0, 3};
        check_tids("t5_tid", exp_ids);

        // random traffic with random sink backpressure
        do_reset(3);
        clear_log();
        pushed  = 0;
        rnd_rdy = 1'b1;
        for (int c = 0; c < 800; c++) begin
            for (int unsigned p = 0; p < N; p++) begin
                if (src_q[p].size() < 4 && $urandom_range(0, 7) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int unsigned b = 0; b < len; b++) begin
                        push_beat(p, b == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                        pushed++;
                    end
                end
            end
            step();
        end
        rnd_rdy  = 1'b0;
        want_rdy = 1'b1;
        drain("rand_drain", 400);
        check("rand_beats", 64'(out_tid.size()), 64'(pushed));

`ifdef AXIS_ARB_STATS_EN
        // packet counters: 3 packets on port 2, 1 on port 0, then clear
        do_reset(3);
        for (int k = 0; k < 3; k++) begin
            push_beat(2, 1'b0, 0);
            push_beat(2, 1'b1, 0);
        end
        push_beat(0, 1'b1, 0);
        drain("stat_drain", 60);
        check("stat_p0", 64'(stat_pkts[0*16 +: 16]), 64'(1));
        check("stat_p1", 64'(stat_pkts[1*16 +: 16]), 64'(0));
        check("stat_p2", 64'(stat_pkts[2*16 +: 16]), 64'(3));
        check("stat_p3", 64'(stat_pkts[3*16 +: 16]), 64'(0));
        want_clr = 1'b1;
        step();
        want_clr = 1'b0;
        step();
        check("stat_clr", 64'(stat_pkts), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
